// File: rtl/i2c_master_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_master_arbiter - round-robin sharing of one I2C master between two
// requesters, launching each transaction by releasing the master's reset. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_master_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       err,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       m_rst,
  output logic       m_rw,
  inout  wire  [7:0] m_data,
  input  logic [2:0] m_state
);

  localparam int            CW         = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);
  localparam logic [2:0]    M_DONE     = 3'd5;
  localparam logic [1:0]    S_IDLE     = 2'd0;
  localparam logic [1:0]    S_START    = 2'd1;
  localparam logic [1:0]    S_RUN      = 2'd2;
  localparam logic [1:0]    S_COMPLETE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic          m_rst_q, m_rst_d;
  logic          m_rw_q, m_rw_d;
  logic [7:0]    wbuf_q, wbuf_d;
  logic          drive_q, drive_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic owner_sel;
  logic sel_rw;
  logic run_done;
  logic run_tout;

  // On contention the requester that did not finish last wins.
  assign owner_sel = (req[0] & req[1]) ? ~last_q : req[1];
  assign sel_rw    = owner_sel ? rw1 : rw0;
  assign run_done  = (m_state == M_DONE);
  assign run_tout  = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
      busy_q  <= 1'b0;
      m_rst_q <= 1'b1;
      m_rw_q  <= 1'b0;
      wbuf_q  <= 8'h00;
      drive_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      m_rst_q <= m_rst_d;
      m_rw_q  <= m_rw_d;
      wbuf_q  <= wbuf_d;
      drive_q <= drive_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (|req) state_d = S_START;
      S_START:    state_d = S_RUN;
      S_RUN:      if (run_done || run_tout) state_d = S_COMPLETE;
      S_COMPLETE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    err_d   = err_q;
    rdata_d = rdata_q;
    busy_d  = (state_d != S_IDLE);
    m_rst_d = 1'b1;
    m_rw_d  = m_rw_q;
    wbuf_d  = wbuf_q;
    drive_d = drive_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d   = owner_sel ? 2'b10 : 2'b01;
          m_rw_d  = sel_rw;
          wbuf_d  = owner_sel ? wdata1 : wdata0;
          drive_d = ~sel_rw;
        end
      end
      S_START: begin
        m_rst_d = 1'b0;
        cnt_d   = '0;
      end
      S_RUN: begin
        // A DONE seen on the timeout cycle still counts as success.
        if (run_done) begin
          done_d  = gnt_q;
          err_d   = 1'b0;
          drive_d = 1'b0;
          if (m_rw_q) rdata_d = m_data;
        end else if (run_tout) begin
          done_d  = gnt_q;
          err_d   = 1'b1;
          drive_d = 1'b0;
        end else begin
          m_rst_d = 1'b0;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_COMPLETE: begin
        gnt_d  = 2'b00;
        last_d = gnt_q[1];
      end
      default: ;
    endcase
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign err    = err_q;
  assign rdata  = rdata_q;
  assign busy   = busy_q;
  assign m_rst  = m_rst_q;
  assign m_rw   = m_rw_q;
  assign m_data = drive_q ? wbuf_q : 8'hzz;

endmodule

`default_nettype wire

// File: doc/i2c_master_arbiter.md
# i2c_master_arbiter

Shares the single I2C `master` instance between two requesters and sequences each transaction through it. The master has no start strobe. The arbiter therefore holds it in reset while idle, releases reset to launch a transaction, and watches its `state` output for DONE. It then captures read data, returns the master to reset and hands completion back to the winning requester. A watchdog recovers from a master that never reaches DONE.

## Interface
- `TIMEOUT`, default 1024: max cycles spent in RUN before forced abort; must be ≥ 2.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `req`  in  2  per-requester transaction request, level; held until matching `done`.
- `rw0`, `rw1`  in  1 each  requester direction, 1 = read, 0 = write; sampled at grant.
- `wdata0`, `wdata1`  in  8 each  requester write byte; sampled at grant.
- `gnt`  out  2  one-hot owner of the master, 0 while idle.
- `done`  out  2  one-cycle completion pulse to the owner.
- `err`  out  1  valid with `done`: 1 = watchdog abort; holds until next `done`.
- `rdata`  out  8  captured read byte; valid from `done` until next read completes.
- `busy`  out  1  high whenever state ≠ IDLE.
- `m_rst`  out  1  active-high reset to master; high holds it idle.
- `m_rw`  out  1  direction to master, latched copy of owner's rw.
- `m_data`  inout  8  master data bus; driven with latched wdata only for writes in START/RUN, else high-Z.
- `m_state`  in  3  master state: 0 IDLE, 1 ADDRESSING, 2 WAITING, 3 READING, 4 WRITING, 5 DONE.

## Operation
- FSM states: IDLE, START, RUN, COMPLETE.
- IDLE: `m_rst`=1. If any `req` bit is set, select the owner, latch its rw/wdata into `m_rw`/wbuf, set `gnt`, then go to START.
- Arbitration is round-robin. A single request wins outright. When both are set, the requester other than `last` wins. `last` resets to 1, so requester 0 wins first.
- START, one cycle: `m_rst` stays 1, and `m_rw`/`m_data` are stable as setup for the master. Then go to RUN. The watchdog counter is cleared.
- RUN: `m_rst`=0, and the counter increments every cycle.
  - `m_state`==5 sampled: go to COMPLETE with err=0. If `m_rw`=1, `rdata` ← `m_data` on the same edge.
  - Otherwise, counter == TIMEOUT−1: go to COMPLETE with err=1, `rdata` unchanged.
  - DONE and timeout on the same edge: DONE wins, err=0.
- COMPLETE, one cycle: `m_rst`=1, `done[owner]`=1, `err` updated, `last` ← owner, `gnt` stays set this cycle. Then go to IDLE, where `gnt` clears.
- Transactions are never aborted by requesters. A `req` dropped early has no effect on the cycle. After `done`, the owner must drop `req` or it becomes eligible again. With the other requester pending, round-robin still alternates.
- Counter width is $clog2(TIMEOUT). It never wraps, because RUN always exits at TIMEOUT−1.
- `m_data` is high-Z during reads, IDLE and COMPLETE, so the master or slave can drive it.

## Timing
- Reset values: state=IDLE, `gnt`=0, `done`=0, `err`=0, `rdata`=8'h00, `busy`=0, `m_rst`=1, `m_rw`=0, `m_data`=Z, `last`=1, counter=0.
- Reset mid-transaction immediately forces the reset values. `m_rst`=1 puts the master back in reset. No `done` is issued.
- Latency: `req` seen at edge k gives `gnt` and START after edge k, RUN (`m_rst`=0) after edge k+1. DONE sampled at edge d gives `done` high for the cycle after edge d. The next grant is possible at edge d+2.
- Earliest back-to-back: 3 cycles of overhead (IDLE, START, COMPLETE) plus the RUN length per transaction.
- All outputs are registered.

## Test plan
- Single write: req=01, rw0=0, wdata0=8'hA5, and a model raises `m_state`=5 after 20 RUN cycles.
  - Required: `gnt`=01, `m_data`=A5 throughout START/RUN, `done`=01 for 1 cycle, `err`=0, `m_rst` back to 1.
- Single read: req=10, rw1=1; the model drives `m_data`=8'hF6 with `m_state`=5.
  - Required: `m_data` high-Z from the arbiter, `rdata`=F6 at `done`=10, `err`=0.
- Contention: req=11 held continuously.
  - Required: grants alternate 01, 10, 01, 10. Each `done` matches the preceding `gnt`.
- Watchdog: TIMEOUT=16, `m_state` stuck at 2.
  - Required: exactly 16 RUN cycles, then `done` with `err`=1 and `rdata` unchanged. The next successful transaction clears `err`.
- Reset mid-RUN: pull `rst` low during RUN of a read.
  - Required: immediately `m_rst`=1, `gnt`=0, `busy`=0, no `done`. After release, a pending request is granted normally, with requester 0 first.
- Simultaneous DONE and timeout: TIMEOUT=8, `m_state`=5 on the 8th RUN cycle.
  - Required: `err`=0, `rdata` captured.
